// File: rtl/ifetch_pkg.sv
// Shared core definitions for the fetch stage and the Decoder interface.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          IMEM_ADDR_W      = 14;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns the PC, fetches one word at a time over a
// req/ack handshake and holds the fetched instruction for the Decoder.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       target_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc4_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              align_err_o,
  output logic [31:0]       fetch_cnt_o
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic [31:0]  cnt;
  logic         valid;
  logic         req;
  logic         align_err;
  logic [31:0]  tgt;
  logic         tgt_misaligned;

  assign tgt            = word_align(target_i);
  assign tgt_misaligned = |target_i[1:0];

  // Redirect outranks both ack and stall; in REQ it simply retargets the
  // outstanding request, so the memory sees a withdrawal of the old address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= INSTR_NOP;
      cnt       <= '0;
      valid     <= 1'b0;
      req       <= 1'b0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (redirect_i) begin
            pc        <= tgt;
            align_err <= tgt_misaligned;
          end else if (imem_ack_i) begin
            instr <= imem_rdata_i;
            valid <= 1'b1;
            req   <= 1'b0;
            state <= VALID;
          end
        end
        VALID: begin
          if (redirect_i) begin
            pc        <= tgt;
            align_err <= tgt_misaligned;
            valid     <= 1'b0;
            instr     <= INSTR_NOP;
            req       <= 1'b1;
            state     <= REQ;
          end else if (!stall_i) begin
            pc    <= pc + 32'd4;
            cnt   <= cnt + 32'd1;
            valid <= 1'b0;
            instr <= INSTR_NOP;
            req   <= 1'b1;
            state <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          valid <= 1'b0;
          instr <= INSTR_NOP;
        end
      endcase
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc[ADDR_W+1:2];
  assign valid_o     = valid;
  assign instr_o     = instr;
  assign pc_o        = pc;
  assign pc4_o       = pc + 32'd4;
  assign addr_o      = pc[ADDR_W+1:2];
  assign align_err_o = align_err;
  assign fetch_cnt_o = cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed plus randomized bench for ifetch_unit against a cycle-level
// behavioural model of the fetch rules.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, imem_req_o, imem_ack_i, stall_i, redirect_i;
  logic        valid_o, align_err_o;
  logic [13:0] imem_addr_o, addr_o;
  logic [31:0] imem_rdata_i, target_i, instr_o, pc_o, pc4_o, fetch_cnt_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [64];

  // model: boot = the single idle cycle, wait = request outstanding, have = instr held
  bit          m_boot, m_wait, m_have, m_aerr;
  logic [31:0] m_pc, m_instr, m_cnt;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .target_i(target_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc4_o(pc4_o),
    .addr_o(addr_o), .align_err_o(align_err_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("valid",   {31'b0, valid_o},     {31'b0, m_have});
    chk("instr",   instr_o,              m_instr);
    chk("pc",      pc_o,                 m_pc);
    chk("pc4",     pc4_o,                m_pc + 32'd4);
    chk("addr",    {18'b0, addr_o},      {18'b0, m_pc[15:2]});
    chk("req",     {31'b0, imem_req_o},  {31'b0, m_wait});
    chk("imaddr",  {18'b0, imem_addr_o}, {18'b0, m_pc[15:2]});
    chk("alerr",   {31'b0, align_err_o}, {31'b0, m_aerr});
    chk("cnt",     fetch_cnt_o,          m_cnt);
  endtask

  task automatic step(input bit rst, input bit ack, input bit stall,
                      input bit redir, input logic [31:0] tgt);
    rst_n        = rst;
    imem_ack_i   = ack;
    stall_i      = stall;
    redirect_i   = redir;
    target_i     = tgt;
    imem_rdata_i = rom[imem_addr_o[5:0]];
    if (!rst) begin
      m_boot = 1; m_wait = 0; m_have = 0; m_aerr = 0;
      m_pc = 32'h0; m_instr = INSTR_NOP; m_cnt = 0;
    end else begin
      m_aerr = 0;
      if (m_boot) begin
        m_boot = 0; m_wait = 1;
      end else if ((m_wait || m_have) && redir) begin
        m_pc = tgt & 32'hFFFF_FFFC; m_have = 0; m_instr = INSTR_NOP;
        m_wait = 1; m_aerr = (tgt[1:0] != 2'b00);
      end else if (m_wait && ack) begin
        m_instr = rom[m_pc[7:2]]; m_have = 1; m_wait = 0;
      end else if (m_have && !stall) begin
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        m_have = 0; m_instr = INSTR_NOP; m_wait = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h0060_0513;
    rom[1] = 32'h00d6_05b3;
    rst_n = 0; imem_ack_i = 0; stall_i = 0; redirect_i = 0;
    target_i = 0; imem_rdata_i = 0;

    // reset and first request
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("rel_req", {31'b0, imem_req_o}, 32'd1);
    chk("rel_addr", {18'b0, imem_addr_o}, 32'd0);

    // zero-wait sequential fetch
    step(1, 1, 0, 0, 0);
    chk("w0_instr", instr_o, 32'h0060_0513);
    chk("w0_pc4", pc4_o, 32'd4);
    step(1, 0, 0, 0, 0);
    chk("w0_drop", {31'b0, valid_o}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("w1_instr", instr_o, 32'h00d6_05b3);
    chk("w1_addr", {18'b0, addr_o}, 32'd1);
    step(1, 0, 0, 0, 0);
    chk("cnt2", fetch_cnt_o, 32'd2);

    // ack delayed three cycles
    repeat (3) step(1, 0, 0, 0, 0);
    chk("dly_addr", {18'b0, imem_addr_o}, 32'd2);
    step(1, 1, 0, 0, 0);
    chk("dly_valid", {31'b0, valid_o}, 32'd1);

    // stall holds output
    repeat (2) step(1, 0, 1, 0, 0);
    chk("stall_pc", pc_o, 32'd8);
    chk("stall_req", {31'b0, imem_req_o}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("unstall_addr", {18'b0, imem_addr_o}, 32'd3);

    // redirect vs same-cycle ack, then redirect vs stall
    step(1, 1, 0, 1, 32'h0000_000c);
    chk("rd_ack_valid", {31'b0, valid_o}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("rd_pc", pc_o, 32'h0000_000c);
    step(1, 0, 1, 1, 32'h0000_0040);
    chk("rd_stall_cnt", fetch_cnt_o, 32'd3);
    step(1, 1, 0, 0, 0);

    // misaligned redirect and reset during a pending request
    step(1, 0, 0, 1, 32'h0000_000e);
    chk("mis_pc", pc_o, 32'h0000_000c);
    chk("mis_err", {31'b0, align_err_o}, 32'd1);
    step(1, 0, 0, 0, 0);
    chk("mis_err_off", {31'b0, align_err_o}, 32'd0);
    step(0, 1, 0, 0, 0);
    chk("mid_rst_pc", pc_o, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("late_ack", {31'b0, valid_o}, 32'd0);

    // PC and word-address wrap
    step(1, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 0);
    chk("wrap_pc4", pc4_o, 32'd0);
    chk("wrap_addr", {18'b0, addr_o}, 32'h0000_3fff);
    step(1, 0, 0, 0, 0);
    chk("wrap_pc", pc_o, 32'd0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? $urandom : {24'b0, 8'($urandom_range(0, 255))};
      step($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
